// File: rtl/vpu_dma_pkg.sv
// Shared types for the BRAM copy DMA: controller state encoding and source read latency.
package vpu_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam int RD_LAT = 1;

endpackage

// File: rtl/bram_copy_dma.sv
// Single-port-pair BRAM copy engine: streams len words from src_base to dst_base at one word per cycle.
// Optional constant-fill mode is enabled by defining BRAM_DMA_FILL_EN.
module bram_copy_dma
  import vpu_dma_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic [ADDR_W:0]   len,
`ifdef BRAM_DMA_FILL_EN
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_val,
`endif
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  dma_state_t r_state;
  dma_state_t w_state_next;

  logic [ADDR_W-1:0] r_src_addr;
  logic [ADDR_W-1:0] r_dst_addr;
  logic [ADDR_W:0]   r_remain;
  logic [RD_LAT-1:0] r_rd_pipe;

  logic w_accept;
  logic w_rd_en;
  logic w_wr_en;
  logic w_busy;
  logic w_done;
  logic w_last;
  logic w_fill_mode;

`ifdef BRAM_DMA_FILL_EN
  logic              r_fill;
  logic [DATA_W-1:0] r_fill_val;

  assign w_fill_mode = r_fill;
  assign wr_data     = r_fill ? r_fill_val : rd_data;
`else
  assign w_fill_mode = 1'b0;
  assign wr_data     = rd_data;
`endif

  assign w_last = (r_remain == LEN_ONE);

  // A write is due whenever a read issued RD_LAT cycles ago returns, or directly while filling.
  assign w_wr_en = r_rd_pipe[RD_LAT-1] | (w_fill_mode & (r_state == RUN));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_rd_en      = 1'b0;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_state_next = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        w_busy  = 1'b1;
        w_rd_en = ~w_fill_mode;
        if (w_last) begin
          w_state_next = w_fill_mode ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        w_busy       = 1'b1;
        w_state_next = DONE;
      end
      DONE: begin
        w_done       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_src_addr <= '0;
      r_dst_addr <= '0;
      r_remain   <= '0;
      r_rd_pipe  <= '0;
`ifdef BRAM_DMA_FILL_EN
      r_fill     <= 1'b0;
      r_fill_val <= '0;
`endif
    end else begin
      r_rd_pipe[0] <= w_rd_en;
      for (int i = 1; i < RD_LAT; i++) begin
        r_rd_pipe[i] <= r_rd_pipe[i-1];
      end
      if (w_accept) begin
        r_src_addr <= src_base;
        r_dst_addr <= dst_base;
        r_remain   <= len;
`ifdef BRAM_DMA_FILL_EN
        r_fill     <= fill;
        r_fill_val <= fill_val;
`endif
      end else begin
        // Addresses wrap naturally at 2**ADDR_W.
        if (r_state == RUN) begin
          r_src_addr <= r_src_addr + ADDR_ONE;
          r_remain   <= r_remain - LEN_ONE;
        end
        if (w_wr_en) begin
          r_dst_addr <= r_dst_addr + ADDR_ONE;
        end
      end
    end
  end

  assign rd_en   = w_rd_en;
  assign rd_addr = r_src_addr;
  assign wr_en   = w_wr_en;
  assign wr_addr = r_dst_addr;
  assign busy    = w_busy;
  assign done    = w_done;

endmodule

// File: doc/bram_copy_dma.md
BRAM_COPY_DMA -- requirements
Module: bram_copy_dma

Interface
REQ-001 Parameter ADDR_W, default 8, BRAM address width in bits.
REQ-002 Parameter DATA_W, default 8, BRAM data width in bits.
REQ-003 clk  in  1  single clock; all logic on its rising edge.
REQ-004 rst_n  in  1  reset, synchronous, active-low.
REQ-005 start  in  1  request a transfer; sampled only in IDLE.
REQ-006 src_base  in  ADDR_W  first source address.
REQ-007 dst_base  in  ADDR_W  first destination address.
REQ-008 len  in  ADDR_W+1  word count, 0 to 2**ADDR_W.
REQ-009 rd_en, rd_addr  out  1, ADDR_W  read request to the source BRAM port.
REQ-010 rd_data  in  DATA_W  source BRAM read data, valid the cycle after rd_en.
REQ-011 wr_en, wr_addr, wr_data  out  1, ADDR_W, DATA_W  write request to the destination BRAM port.
REQ-012 busy  out  1  transfer in progress.
REQ-013 done  out  1  one-cycle completion pulse.

Function
REQ-014 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE to RUN on start with len>0; IDLE to DONE on start with len==0; otherwise stay in IDLE.
REQ-016 src_base, dst_base and len are latched at the cycle start is accepted (cycle 0); later input changes do not affect the transfer.
REQ-017 For len=N>=1: rd_en high in cycles 1..N, rd_addr = src_base+k-1 in cycle k.
REQ-018 wr_en high in cycles 2..N+1, wr_addr = dst_base+k-2 in cycle k, wr_data = rd_data in the same cycle (combinational pass-through, no extra register).
REQ-019 RUN lasts cycles 1..N, DRAIN is cycle N+1, DONE is cycle N+2, then return to IDLE.
REQ-020 Throughput one word per cycle; total latency from start to done is N+2 cycles.
REQ-021 busy is high in the RUN and DRAIN states, low in IDLE and DONE.
REQ-022 done is high only in the DONE state.
REQ-023 len==0: no rd_en or wr_en; done pulses in cycle 1; busy stays low.
REQ-024 Address arithmetic is modulo 2**ADDR_W; wrap-around from all-ones to zero is legal for source and destination.
REQ-025 start while not in IDLE is ignored; no queuing.
REQ-026 start may be held high; a new transfer is accepted only in the cycle after done (IDLE).
REQ-027 Outputs rd_addr, wr_addr and wr_data are don't-care when the matching enable is low; the bench checks them only when enabled.
REQ-028 dst_base==src_base rewrites identical data.
REQ-029 Overlapping ranges with dst in (src, src+len) are unsupported; the result is unspecified.

Reset
REQ-030 rst_n low at a clock edge forces IDLE; rd_en, wr_en, busy and done are 0 and all latched registers are 0.
REQ-031 Reset during RUN or DRAIN aborts immediately: no further writes and no done pulse.

Configuration
REQ-032 Macro BRAM_DMA_FILL_EN, when defined, adds input fill (1 bit, latched with start) and input fill_val (DATA_W bits, latched with start).
REQ-033 Transfer with fill=1: rd_en stays 0; wr_en is high in cycles 1..N with wr_data = fill_val; DRAIN is skipped; done pulses in cycle N+1.
REQ-034 Without the macro: no fill ports exist and every transfer is a copy.

Structure
REQ-035 Package vpu_dma_pkg holds the FSM state enum (dma_state_t) and the localparam for the read latency (RD_LAT=1).
REQ-036 No sub-module; single flat module with one address/count datapath.

Verification
REQ-037 Copy: src=0x10, dst=0x80, len=4, source holds A0..A3 -> dst 0x80..0x83 = A0..A3; done at cycle 6; busy high in cycles 1..5.
REQ-038 Wrap: src=0xFE, dst=0xFF, len=3 -> reads 0xFE, 0xFF, 0x00; writes 0xFF, 0x00, 0x01.
REQ-039 len=0 -> no enables; done in cycle 1; len=256 -> full 256-word copy, done in cycle 258.
REQ-040 start pulsed again in cycle 2 of a len=4 transfer -> ignored; a start held high -> second transfer begins in the cycle after done.
REQ-041 rst_n low in cycle 3 of a len=8 transfer -> enables drop at the next edge; no done pulse; only dst+0 and dst+1 written.
REQ-042 With BRAM_DMA_FILL_EN: fill=1, fill_val=0x5A, dst=0x20, len=3 -> 0x20..0x22 = 0x5A; rd_en never high; done in cycle 4.
